// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, MDU occupancy FSM, branch flush, external stall.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_MduStart,
  input  logic        ID_MduRead,
  input  logic        EXE_ReadMen,
  input  logic [4:0]  EXE_RwAddr,
  input  logic        EX_BranchTaken,
  input  logic        Ext_Stall,
  output logic        PC_Wr,
  output logic        IF_ID_Wr,
  output logic        IF_ID_Flush,
  output logic        ID_EX_REG_WR,
  output logic        ID_EX_Flush,
  output logic        Mdu_Busy,
  output logic [31:0] Stall_Cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             loadUse, mduHazard, accept;

  always_comb begin
    loadUse = EXE_ReadMen && (EXE_RwAddr != 5'd0) &&
              ((ID_UseRs && (ID_rs == EXE_RwAddr)) || (ID_UseRt && (ID_rt == EXE_RwAddr)));
    Mdu_Busy  = (state == BUSY) && !rst;
    mduHazard = Mdu_Busy && (ID_MduStart || ID_MduRead);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Accept is gated by the flush so a wrong-path or stalled mult/div never starts the MDU.
  always_comb begin
    accept    = ID_MduStart && ID_EX_REG_WR && !ID_EX_Flush && !rst;
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    PC_Wr        = 1'b1;
    IF_ID_Wr     = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_REG_WR = 1'b1;
    ID_EX_Flush  = 1'b0;
    if (rst) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (Ext_Stall) begin
      PC_Wr        = 1'b0;
      IF_ID_Wr     = 1'b0;
      ID_EX_REG_WR = 1'b0;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (loadUse || mduHazard) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfCnt;
  logic        stallCycle;

  always_comb stallCycle = !rst && !Ext_Stall && !EX_BranchTaken && (loadUse || mduHazard);

  always_ff @(posedge clk) begin
    if (rst)
      perfCnt <= '0;
    else if (stallCycle)
      perfCnt <= perfCnt + 32'd1;
  end

  assign Stall_Cnt = rst ? '0 : perfCnt;
`else
  assign Stall_Cnt = '0;
`endif

endmodule
